add_sub_seq: RTL and testbench
==============================

ADD_SUB_SEQ -- requirements
Module: add_sub_seq

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits; legal values are WIDTH >= 1.
REQ-002 Parameter: DIGIT, 4, bits processed per cycle; legal values are 1 <= DIGIT <= WIDTH with WIDTH % DIGIT == 0; NDIG = WIDTH/DIGIT.
REQ-003 Port: CLK  input  1  sole clock, rising edge.
REQ-004 Port: ASYNCRESETN  input  1  reset, asynchronous, active-low.
REQ-005 Port: I_VALID  input  1  request valid.
REQ-006 Port: I_READY  output  1  request accepted when high together with I_VALID.
REQ-007 Port: I0  input  WIDTH  minuend/addend A.
REQ-008 Port: I1  input  WIDTH  subtrahend/addend B.
REQ-009 Port: SUB  input  1  0 = add, 1 = subtract; sampled with the request.
REQ-010 Port: CIN  input  1  carry-in (add) or borrow-in (sub); sampled with the request.
REQ-011 Port: O_VALID  output  1  result valid.
REQ-012 Port: O_READY  input  1  consumer takes result when high together with O_VALID.
REQ-013 Port: O  output  WIDTH  result, registered.
REQ-014 Port: COUT  output  1  carry-out (add) or borrow-out (sub), registered.
REQ-015 Port: V  output  1  two's-complement signed overflow, registered.

Function
REQ-016 Add: {COUT,O} SHALL equal I0 + I1 + CIN, computed at (WIDTH+1) bits.
REQ-017 Sub: O SHALL equal (I0 - I1 - CIN) mod 2^WIDTH, implemented as I0 + ~I1 + ~CIN; COUT SHALL be the inverted internal carry, i.e. 1 exactly when unsigned I0 < I1 + CIN.
REQ-018 V SHALL be 1 exactly when the carry into the MSB differs from the internal carry out of the MSB, regardless of SUB.
REQ-019 FSM states: IDLE, RUN, DONE.
REQ-020 IDLE: I_READY = 1, O_VALID = 0; I_VALID high at a rising edge latches I0, I1, SUB, CIN and moves to RUN with digit counter = 0.
REQ-021 RUN: I_READY = 0, O_VALID = 0; each cycle adds one DIGIT-bit slice, LS slice first, with a registered internal carry between slices, and increments the counter.
REQ-022 The edge that processes slice NDIG-1 SHALL move to DONE and update O, COUT and V in the same edge.
REQ-023 Latency: O_VALID SHALL rise exactly NDIG cycles after the accepting edge; this includes NDIG = 1 (DIGIT = WIDTH).
REQ-024 DONE: O_VALID = 1, I_READY = 0; O, COUT and V SHALL hold stable until the edge with O_READY = 1, which moves to IDLE.
REQ-025 Throughput: one operation per NDIG+1 cycles at minimum; a request is not accepted on the cycle a result is consumed.
REQ-026 O, COUT and V SHALL retain the last result in IDLE and RUN until the next transition into DONE.
REQ-027 Operand inputs, SUB and CIN changing while the block is in RUN or DONE SHALL have no effect.
REQ-028 Partial results SHALL never be visible on O; O changes only on entry to DONE.

Reset
REQ-029 ASYNCRESETN low SHALL immediately force state IDLE, I_READY = 1, O_VALID = 0, O = 0, COUT = 0, V = 0, counter = 0, and internal carry = 0, independent of CLK.
REQ-030 Reset asserted in RUN or DONE SHALL discard the operation without producing a result; the first edge after deassertion behaves as IDLE.

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-031 Scenario: add 0x1234 + 0x0FFF with CIN=0 -> O=0x2233, COUT=0, V=0; O_VALID rises 4 cycles after the accept.
REQ-032 Scenario: sub 0x0005 - 0x0007 with CIN=0 -> O=0xFFFE, COUT=1, V=0; and add 0x7FFF + 0x0001 -> O=0x8000, COUT=0, V=1.
REQ-033 Scenario: sub 0x8000 - 0x0001 with CIN=1 -> O=0x7FFE, COUT=0, V=1; and add 0xFFFF + 0x0000 with CIN=1 -> O=0x0000, COUT=1, V=0.
REQ-034 Scenario: O_READY held low 5 cycles in DONE -> O, COUT, V and O_VALID=1 stable, I_READY=0, new I_VALID ignored; O_READY=1 -> IDLE next edge.
REQ-035 Scenario: ASYNCRESETN pulsed low mid-RUN between clock edges -> outputs zero at once, no O_VALID; a following add 0x0001 + 0x0001 -> O=0x0002.
REQ-036 Scenario: DIGIT=16 and DIGIT=1 builds with the vectors of REQ-031 -> identical results, with latency 1 and 16 cycles respectively; plus 1000 random ops checked against a reference model.

Source files
------------

// File: rtl/add_sub_seq.sv
// add_sub_seq: digit-serial adder/subtractor with valid/ready handshakes.
// An accepted request is processed DIGIT bits per cycle, least significant
// slice first, and the full result is published on O/COUT/V in one step.
module add_sub_seq #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             I_VALID,
  output logic             I_READY,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             SUB,
  input  logic             CIN,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic [WIDTH-1:0] O,
  output logic             COUT,
  output logic             V
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic             r_sub;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_o;
  logic             r_cout;
  logic             r_v;

  logic [DIGIT-1:0] w_aslice;
  logic [DIGIT-1:0] w_bslice;
  logic [DIGIT:0]   w_sum;
  logic [WIDTH-1:0] w_ins;
  logic [WIDTH-1:0] w_result;
  logic             w_last;
  logic             w_cmsb_in;
  logic             w_vflag;

  // One slice of the sum: operands are shifted down each cycle, so the
  // current slice always sits in the low DIGIT bits. The finished slice is
  // inserted at the top of the accumulator, which shifts right in step, so
  // after NDIG slices the whole result lines up at bit 0.
  always_comb begin
    w_aslice  = r_a[DIGIT-1:0];
    w_bslice  = r_b[DIGIT-1:0];
    w_sum     = {1'b0, w_aslice} + {1'b0, w_bslice} + {{DIGIT{1'b0}}, r_carry};
    w_ins     = WIDTH'(w_sum[DIGIT-1:0]) << (WIDTH - DIGIT);
    w_result  = (r_acc >> DIGIT) | w_ins;
    w_last    = (r_cnt == LAST);
    w_cmsb_in = w_sum[DIGIT-1] ^ w_aslice[DIGIT-1] ^ w_bslice[DIGIT-1];
    w_vflag   = w_cmsb_in ^ w_sum[DIGIT];
  end

  // Control: IDLE accepts, RUN walks the slices, DONE waits for the consumer.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (I_VALID) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          if (w_last) begin
            r_state <= S_DONE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (O_READY) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Operand capture and slice stepping; subtraction is folded in at capture
  // time as A + ~B + ~CIN so the slice adder never needs to know the mode.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      r_acc   <= '0;
    end else if (r_state == S_IDLE && I_VALID) begin
      r_a     <= I0;
      r_b     <= SUB ? ~I1 : I1;
      r_carry <= SUB ^ CIN;
      r_sub   <= SUB;
      r_acc   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_carry <= w_sum[DIGIT];
      r_acc   <= w_result;
    end
  end

  // Published result registers change only when the last slice completes.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_o    <= '0;
      r_cout <= 1'b0;
      r_v    <= 1'b0;
    end else if (r_state == S_RUN && w_last) begin
      r_o    <= w_result;
      r_cout <= w_sum[DIGIT] ^ r_sub;
      r_v    <= w_vflag;
    end
  end

  assign I_READY = (r_state == S_IDLE);
  assign O_VALID = (r_state == S_DONE);
  assign O       = r_o;
  assign COUT    = r_cout;
  assign V       = r_v;

endmodule

// File: tb/tb_add_sub_seq.sv
// Testbench for add_sub_seq: three builds (DIGIT = 4, 16, 1) share the
// operand bus; each has its own request valid and its own outputs.
module tb_add_sub_seq;

  logic             CLK;
  logic             ASYNCRESETN;
  logic [15:0]      I0;
  logic [15:0]      I1;
  logic             SUB;
  logic             CIN;
  logic             O_READY;
  logic [2:0]       iValid;
  logic [2:0]       iReady;
  logic [2:0]       oValid;
  logic [2:0]       cOut;
  logic [2:0]       vOut;
  logic [2:0][15:0] oRes;

  int total;
  int bad;

  // Index 0: DIGIT=4, index 1: DIGIT=16, index 2: DIGIT=1.
  add_sub_seq #(.WIDTH(16), .DIGIT(4)) dut4 (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .I_VALID(iValid[0]), .I_READY(iReady[0]),
    .I0(I0), .I1(I1), .SUB(SUB), .CIN(CIN), .O_VALID(oValid[0]), .O_READY(O_READY),
    .O(oRes[0]), .COUT(cOut[0]), .V(vOut[0]));

  add_sub_seq #(.WIDTH(16), .DIGIT(16)) dut16 (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .I_VALID(iValid[1]), .I_READY(iReady[1]),
    .I0(I0), .I1(I1), .SUB(SUB), .CIN(CIN), .O_VALID(oValid[1]), .O_READY(O_READY),
    .O(oRes[1]), .COUT(cOut[1]), .V(vOut[1]));

  add_sub_seq #(.WIDTH(16), .DIGIT(1)) dut1 (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .I_VALID(iValid[2]), .I_READY(iReady[2]),
    .I0(I0), .I1(I1), .SUB(SUB), .CIN(CIN), .O_VALID(oValid[2]), .O_READY(O_READY),
    .O(oRes[2]), .COUT(cOut[2]), .V(vOut[2]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected cycles from the accepting edge to O_VALID for each build.
  function automatic int expLat(input int w);
    case (w)
      0:       return 4;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  // Reference model from plain integer arithmetic: returns {V, COUT, O}.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic s, input logic c);
    int sa, sb, ua, ub, ci, sr, ur;
    logic co, ov;
    logic [15:0] o;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    ci = int'(c);
    if (!s) begin
      ur = ua + ub + ci;
      sr = sa + sb + ci;
      co = (ur > 65535);
    end else begin
      ur = ua - ub - ci;
      sr = sa - sb - ci;
      co = (ua < ub + ci);
    end
    o  = 16'(ur);
    ov = (sr > 32767) || (sr < -32768);
    return {ov, co, o};
  endfunction

  // Present a request to build w, then wait (bounded) until its result is valid.
  // oChanges counts cycles where O moved away from its pre-request value early.
  task automatic startOp(input int w, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic c, output int lat, output int oChanges);
    int guard;
    logic [15:0] oBefore;
    guard = 0;
    while (iReady[w] !== 1'b1 && guard < 50) begin
      @(posedge CLK); #1;
      guard++;
    end
    I0 = a; I1 = b; SUB = s; CIN = c;
    iValid[w] = 1'b1;
    oBefore = oRes[w];
    @(posedge CLK); #1;
    iValid[w] = 1'b0;
    I0 = 16'($urandom); I1 = 16'($urandom); SUB = 1'($urandom); CIN = 1'($urandom);
    lat = 0;
    oChanges = 0;
    while (oValid[w] !== 1'b1 && lat < 40) begin
      if (oRes[w] !== oBefore) oChanges++;
      @(posedge CLK); #1;
      lat++;
    end
  endtask

  task automatic finishOp();
    O_READY = 1'b1;
    @(posedge CLK); #1;
    O_READY = 1'b0;
  endtask

  task automatic test_reset();
    ASYNCRESETN = 1'b1;
    iValid = 3'b000; O_READY = 1'b0;
    I0 = 16'h0; I1 = 16'h0; SUB = 1'b0; CIN = 1'b0;
    #1 ASYNCRESETN = 1'b0;
    #2;
    for (int w = 0; w < 3; w++) begin
      total++;
      if ({iReady[w], oValid[w], oRes[w], cOut[w], vOut[w]} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
        bad++;
        $display("[TB] FAIL reset_state dut%0d: got rdy=%b vld=%b o=%h c=%b v=%b want rdy=1 vld=0 o=0000 c=0 v=0",
                 w, iReady[w], oValid[w], oRes[w], cOut[w], vOut[w]);
      end
    end
    @(posedge CLK); @(posedge CLK);
    #3 ASYNCRESETN = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_vectors();
    logic [15:0] va [5] = '{16'h1234, 16'h0005, 16'h7FFF, 16'h8000, 16'hFFFF};
    logic [15:0] vb [5] = '{16'h0FFF, 16'h0007, 16'h0001, 16'h0001, 16'h0000};
    logic        vs [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        vc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [17:0] ve [5] = '{{2'b00, 16'h2233}, {2'b01, 16'hFFFE}, {2'b10, 16'h8000},
                            {2'b10, 16'h7FFE}, {2'b01, 16'h0000}};
    int lat, chg;
    for (int i = 0; i < 5; i++) begin
      startOp(0, va[i], vb[i], vs[i], vc[i], lat, chg);
      total++;
      if ({vOut[0], cOut[0], oRes[0]} !== ve[i]) begin
        bad++;
        $display("[TB] FAIL vector%0d: got v=%b c=%b o=%h want v=%b c=%b o=%h",
                 i, vOut[0], cOut[0], oRes[0], ve[i][17], ve[i][16], ve[i][15:0]);
      end
      total++;
      if (lat !== 4) begin
        bad++;
        $display("[TB] FAIL vector%0d latency: got %0d want 4", i, lat);
      end
      total++;
      if (chg !== 0) begin
        bad++;
        $display("[TB] FAIL vector%0d partial_o: O moved %0d cycles early, want 0", i, chg);
      end
      finishOp();
    end
  endtask

  task automatic test_hold();
    int lat, chg;
    startOp(0, 16'h4321, 16'h1111, 1'b0, 1'b1, lat, chg);
    total++;
    if ({vOut[0], cOut[0], oRes[0]} !== {2'b00, 16'h5433}) begin
      bad++;
      $display("[TB] FAIL hold_result: got v=%b c=%b o=%h want v=0 c=0 o=5433", vOut[0], cOut[0], oRes[0]);
    end
    for (int k = 0; k < 5; k++) begin
      iValid[0] = 1'b1;
      I0 = 16'($urandom); I1 = 16'($urandom); SUB = 1'($urandom); CIN = 1'($urandom);
      @(posedge CLK); #1;
      total++;
      if ({oValid[0], iReady[0], vOut[0], cOut[0], oRes[0]} !== {1'b1, 1'b0, 2'b00, 16'h5433}) begin
        bad++;
        $display("[TB] FAIL hold_cycle%0d: got vld=%b rdy=%b v=%b c=%b o=%h want vld=1 rdy=0 v=0 c=0 o=5433",
                 k, oValid[0], iReady[0], vOut[0], cOut[0], oRes[0]);
      end
    end
    O_READY = 1'b1;
    @(posedge CLK); #1;
    O_READY = 1'b0;
    iValid[0] = 1'b0;
    total++;
    if ({oValid[0], iReady[0]} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL consume_to_idle: got vld=%b rdy=%b want vld=0 rdy=1", oValid[0], iReady[0]);
    end
    @(posedge CLK); #1;
    total++;
    if ({oValid[0], iReady[0], oRes[0]} !== {2'b01, 16'h5433}) begin
      bad++;
      $display("[TB] FAIL idle_retain: got vld=%b rdy=%b o=%h want vld=0 rdy=1 o=5433",
               oValid[0], iReady[0], oRes[0]);
    end
  endtask

  task automatic test_reset_midrun();
    int lat, chg, seen;
    I0 = 16'h00FF; I1 = 16'h0101; SUB = 1'b0; CIN = 1'b0;
    iValid[0] = 1'b1;
    @(posedge CLK); #1;
    iValid[0] = 1'b0;
    @(posedge CLK);
    #3 ASYNCRESETN = 1'b0;
    #1;
    total++;
    if ({iReady[0], oValid[0], oRes[0], cOut[0], vOut[0]} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL midrun_reset: got rdy=%b vld=%b o=%h c=%b v=%b want rdy=1 vld=0 o=0000 c=0 v=0",
               iReady[0], oValid[0], oRes[0], cOut[0], vOut[0]);
    end
    #2 ASYNCRESETN = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge CLK); #1;
      if (oValid[0] === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("[TB] FAIL discarded_op: O_VALID seen %0d cycles, want 0", seen);
    end
    startOp(0, 16'h0001, 16'h0001, 1'b0, 1'b0, lat, chg);
    total++;
    if ({vOut[0], cOut[0], oRes[0]} !== {2'b00, 16'h0002}) begin
      bad++;
      $display("[TB] FAIL after_reset_add: got v=%b c=%b o=%h want v=0 c=0 o=0002", vOut[0], cOut[0], oRes[0]);
    end
    finishOp();
  endtask

  task automatic test_digit_variants();
    int lat, chg;
    for (int w = 1; w < 3; w++) begin
      startOp(w, 16'h1234, 16'h0FFF, 1'b0, 1'b0, lat, chg);
      total++;
      if ({vOut[w], cOut[w], oRes[w]} !== {2'b00, 16'h2233}) begin
        bad++;
        $display("[TB] FAIL digit_dut%0d: got v=%b c=%b o=%h want v=0 c=0 o=2233", w, vOut[w], cOut[w], oRes[w]);
      end
      total++;
      if (lat !== expLat(w)) begin
        bad++;
        $display("[TB] FAIL digit_dut%0d latency: got %0d want %0d", w, lat, expLat(w));
      end
      total++;
      if (chg !== 0) begin
        bad++;
        $display("[TB] FAIL digit_dut%0d partial_o: O moved %0d cycles early, want 0", w, chg);
      end
      finishOp();
    end
  endtask

  task automatic test_random();
    int lat, chg, w, hold;
    logic [15:0] a, b;
    logic s, c;
    logic [17:0] exp;
    for (int n = 0; n < 1200; n++) begin
      w = (n < 1000) ? 0 : ((n < 1100) ? 1 : 2);
      a = 16'($urandom); b = 16'($urandom);
      s = 1'($urandom); c = 1'($urandom);
      if (n % 50 == 0) a = 16'hFFFF;
      if (n % 50 == 1) b = 16'h0000;
      exp = model(a, b, s, c);
      startOp(w, a, b, s, c, lat, chg);
      hold = $urandom_range(0, 2);
      repeat (hold) begin
        @(posedge CLK); #1;
      end
      total++;
      if ({vOut[w], cOut[w], oRes[w]} !== exp || lat !== expLat(w) || chg !== 0) begin
        bad++;
        $display("[TB] FAIL random%0d dut%0d %h %s %h cin=%b: got v=%b c=%b o=%h lat=%0d early=%0d want v=%b c=%b o=%h lat=%0d early=0",
                 n, w, a, s ? "-" : "+", b, c, vOut[w], cOut[w], oRes[w], lat, chg,
                 exp[17], exp[16], exp[15:0], expLat(w));
      end
      finishOp();
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_vectors();
    test_hold();
    test_reset_midrun();
    test_digit_variants();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
